// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_addsub
//  Description : Pipelined carry-look-ahead adder/subtractor. The operand is
//                split into NSEG = WIDTH/CHUNK segments. Stage k resolves
//                segment k with a flat CHUNK-bit CLA, using the carry that
//                stage k-1 registered. A single global advance signal stalls
//                every stage together, so the last stage register doubles as
//                the output register and holds steady under back-pressure.
//                Optional feature macro: FLAGS_EN (signed overflow, zero and
//                negative flags, registered alongside the result). Without
//                it the flag ports read constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSEG = WIDTH / CHUNK;

    // Carries of one CLA group: c[0] is the group carry-in, c[CHUNK] the
    // group carry-out. Every carry is a flat sum of products of the group
    // generate/propagate terms, so no carry waits on a neighbouring bit.
    function automatic logic [CHUNK:0] f_cla_carries(
        input logic [CHUNK-1:0] i_x,
        input logic [CHUNK-1:0] i_y,
        input logic             i_cin
    );
        logic [CHUNK-1:0] w_g;
        logic [CHUNK-1:0] w_p;
        logic [CHUNK:0]   w_c;
        logic             w_acc;
        logic             w_pprod;
        w_g    = i_x & i_y;
        w_p    = i_x ^ i_y;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int j = 1; j <= CHUNK; j++) begin
            w_acc   = 1'b0;
            w_pprod = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                w_acc   = w_acc | (w_pprod & w_g[i]);
                w_pprod = w_pprod & w_p[i];
            end
            w_c[j] = w_acc | (w_pprod & i_cin);
        end
        return w_c;
    endfunction

    // Stage registers: index k holds what stage k produced.
    logic             r_v [NSEG];
    logic             r_c [NSEG];
    logic [WIDTH-1:0] r_a [NSEG];
    logic [WIDTH-1:0] r_b [NSEG];
    logic [WIDTH-1:0] r_s [NSEG];

    // Stage inputs (what stage k consumes) and stage results.
    logic             w_sv  [NSEG];
    logic             w_sc  [NSEG];
    logic [WIDTH-1:0] w_sa  [NSEG];
    logic [WIDTH-1:0] w_sb  [NSEG];
    logic [WIDTH-1:0] w_ss  [NSEG];
    logic [CHUNK:0]   w_car [NSEG];
    logic [WIDTH-1:0] w_ns  [NSEG];
    logic             w_nc  [NSEG];
    logic             w_adv;

    // Whole pipeline moves only when the output slot is empty or being drained.
    assign w_adv     = !r_v[NSEG-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[NSEG-1];
    assign s         = r_s[NSEG-1];
    assign co        = r_c[NSEG-1];

    // Stage input selection plus per-stage CLA of the segment it owns.
    // Stage 0 zeroes its operands when no beat is offered so that bubbles
    // carry clean data and undriven inputs never reach the outputs.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            w_sv[k]  = 1'b0;
            w_sc[k]  = 1'b0;
            w_sa[k]  = '0;
            w_sb[k]  = '0;
            w_ss[k]  = '0;
            w_car[k] = '0;
            w_ns[k]  = '0;
            w_nc[k]  = 1'b0;
        end
        w_sv[0] = in_valid;
        w_sa[0] = in_valid ? a : '0;
        w_sb[0] = in_valid ? (sub ? ~b : b) : '0;
        w_sc[0] = in_valid & (ci ^ sub);
        for (int k = 1; k < NSEG; k++) begin
            w_sv[k] = r_v[k-1];
            w_sc[k] = r_c[k-1];
            w_sa[k] = r_a[k-1];
            w_sb[k] = r_b[k-1];
            w_ss[k] = r_s[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            w_car[k] = f_cla_carries(w_sa[k][k*CHUNK +: CHUNK],
                                     w_sb[k][k*CHUNK +: CHUNK], w_sc[k]);
            w_ns[k]  = w_ss[k];
            w_ns[k][k*CHUNK +: CHUNK] = w_sa[k][k*CHUNK +: CHUNK]
                                      ^ w_sb[k][k*CHUNK +: CHUNK]
                                      ^ w_car[k][CHUNK-1:0];
            w_nc[k]  = w_car[k][CHUNK];
        end
    end

    // Pipeline registers: reset clears everything, otherwise shift on advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k] <= w_sv[k];
                r_c[k] <= w_nc[k];
                r_a[k] <= w_sa[k];
                r_b[k] <= w_sb[k];
                r_s[k] <= w_ns[k];
            end
        end
    end

`ifdef FLAGS_EN
    logic w_cmsb;
    logic r_ovf;
    logic r_zero;
    logic r_neg;

    // Carry into the MSB is the carry into the top bit of the last group.
    assign w_cmsb = w_car[NSEG-1][CHUNK-1];

    // Status flags registered in step with the final result stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv) begin
            r_ovf  <= w_cmsb ^ w_nc[NSEG-1];
            r_zero <= (w_ns[NSEG-1] == '0);
            r_neg  <= w_ns[NSEG-1][WIDTH-1];
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign neg  = r_neg;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
    assign neg  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_addsub
//  Description : Directed checks on a WIDTH=32/CHUNK=4 instance plus a
//                scoreboard shared by further instances (CHUNK=1, 8, 32 and
//                WIDTH=16) fed the same stimulus. Build with or without
//                FLAGS_EN to cover both flag configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;

    localparam int NDUT = 5;
`ifdef FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;

    logic [NDUT-1:0] w_ir;
    logic [NDUT-1:0] w_ov;
    logic [NDUT-1:0] w_co;
    logic [NDUT-1:0] w_ovf;
    logic [NDUT-1:0] w_zero;
    logic [NDUT-1:0] w_neg;
    logic [31:0]     w_s [NDUT];
    logic [15:0]     w_s16;

    int n_chk = 0;
    int n_err = 0;

    logic [35:0] q_exp [NDUT][$];

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .CHUNK(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_ir[0]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(w_ov[0]), .out_ready(out_ready),
        .s(w_s[0]), .co(w_co[0]), .ovf(w_ovf[0]), .zero(w_zero[0]), .neg(w_neg[0]));

    cla_pipe_addsub #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_ir[1]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(w_ov[1]), .out_ready(out_ready),
        .s(w_s[1]), .co(w_co[1]), .ovf(w_ovf[1]), .zero(w_zero[1]), .neg(w_neg[1]));

    cla_pipe_addsub #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_ir[2]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(w_ov[2]), .out_ready(out_ready),
        .s(w_s[2]), .co(w_co[2]), .ovf(w_ovf[2]), .zero(w_zero[2]), .neg(w_neg[2]));

    cla_pipe_addsub #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_ir[3]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(w_ov[3]), .out_ready(out_ready),
        .s(w_s[3]), .co(w_co[3]), .ovf(w_ovf[3]), .zero(w_zero[3]), .neg(w_neg[3]));

    cla_pipe_addsub #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_ir[4]),
        .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub), .out_valid(w_ov[4]),
        .out_ready(out_ready), .s(w_s16), .co(w_co[4]), .ovf(w_ovf[4]),
        .zero(w_zero[4]), .neg(w_neg[4]));

    assign w_s[4] = {16'h0000, w_s16};

    // One comparison: count it, report it if it differs.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result {ovf,zero,neg,co,s} for a w-bit add/subtract.
    function automatic logic [35:0] f_ref(input int w, input logic [31:0] ia,
                                          input logic [31:0] ib, input logic ici,
                                          input logic isub);
        logic [31:0] msk;
        logic [31:0] xa;
        logic [31:0] xb;
        logic [32:0] sum;
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
        msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        xa  = ia & msk;
        xb  = (isub ? ~ib : ib) & msk;
        sum = {1'b0, xa} + {1'b0, xb} + {32'd0, ici ^ isub};
        r   = sum[31:0] & msk;
        c   = sum[w];
        o   = (xa[w-1] == xb[w-1]) && (r[w-1] != xa[w-1]);
        z   = (r == 32'd0);
        n   = r[w-1];
        return {o & FL, z & FL, n & FL, c, r};
    endfunction

    // Scoreboard for every instance: expect on accept, compare on pop.
    always @(negedge clk) begin : p_sb
        logic [35:0] e;
        if (!reset_n) begin
            for (int d = 0; d < NDUT; d++) q_exp[d].delete();
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                if (w_ov[d] && out_ready) begin
                    if (q_exp[d].size() == 0) begin
                        chk($sformatf("sb%0d_unexpected", d), 64'd1, 64'd0);
                    end else begin
                        e = q_exp[d].pop_front();
                        chk($sformatf("sb%0d_result", d),
                            {28'd0, w_ovf[d], w_zero[d], w_neg[d], w_co[d], w_s[d]},
                            {28'd0, e});
                    end
                end
                if (in_valid && w_ir[d])
                    q_exp[d].push_back(f_ref((d == 4) ? 16 : 32, a, b, ci, sub));
            end
        end
    end

    // One beat through the main instance: latency, result and flags.
    task automatic run_single(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                              input logic ici, input logic isub, input logic [31:0] es,
                              input logic eco, input logic eovf, input logic ezero,
                              input logic eneg);
        int lat;
        a = ia; b = ib; ci = ici; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        lat = 1;
        while (!w_ov[0] && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        chk({tag, "_lat"},  lat,       8);
        chk({tag, "_s"},    w_s[0],    es);
        chk({tag, "_co"},   w_co[0],   eco);
        chk({tag, "_ovf"},  w_ovf[0],  eovf & FL);
        chk({tag, "_zero"}, w_zero[0], ezero & FL);
        chk({tag, "_neg"},  w_neg[0],  eneg & FL);
        @(posedge clk); #2;
    endtask

    logic [32:0] exp_v [20];
    int          n_stray;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", w_ov[0],   1'b0);
        chk("rst_s",     w_s[0],    32'd0);
        chk("rst_co",    w_co[0],   1'b0);
        chk("rst_flags", {w_ovf[0], w_zero[0], w_neg[0]}, 3'b000);
        chk("rst_ready", w_ir[0],   1'b1);
        reset_n = 1'b1;
        @(posedge clk); #2;

        // Directed single beats with hand-derived results.
        run_single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_single("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_single("sub_5m7",  32'd5, 32'd7, 1'b0, 1'b1,
                   32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_single("sub_7m5",  32'd7, 32'd5, 1'b0, 1'b1,
                   32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        run_single("sub_brw",  32'd7, 32'd5, 1'b1, 1'b1,
                   32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_single("sub_ovf",  32'h8000_0000, 32'd1, 1'b0, 1'b1,
                   32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run_single("add_ci",   32'h0000_000F, 32'd0, 1'b1, 1'b0,
                   32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0);

        // 20 back-to-back beats: results on 20 consecutive cycles, in order.
        for (int i = 0; i < 20; i++)
            exp_v[i] = f_ref(32, 32'h0F0F_0F0F * i, 32'hFFFF_FFF0 - 32'(i * 3),
                             i[1], i[0]) & 33'h1_FFFF_FFFF;
        out_ready = 1'b1;
        for (int t = 0; t <= 28; t++) begin
            if (t < 20) begin
                a = 32'h0F0F_0F0F * t; b = 32'hFFFF_FFF0 - 32'(t * 3);
                ci = t[1]; sub = t[0]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk($sformatf("strm_v%0d", t), w_ov[0], (t >= 8 && t < 28));
            if (t >= 8 && t < 28)
                chk($sformatf("strm_d%0d", t - 8), {w_co[0], w_s[0]}, exp_v[t - 8]);
            @(posedge clk); #2;
        end

        // Back-pressure: fill the pipe, hold 5 cycles, release with a beat waiting.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            exp_v[i] = {1'b0, 32'h1000_0000 + 32'(i)} + 33'h0_0000_0100;
        for (int i = 0; i < 8; i++) begin
            a = 32'h1000_0000 + 32'(i); b = 32'h0000_0100; ci = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #2;
        end
        a = 32'h1000_0008; b = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", w_ir[0], 1'b0);
            chk("stall_valid", w_ov[0], 1'b1);
            chk("stall_hold",  {w_co[0], w_s[0]}, exp_v[0]);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("rel_v%0d", j), w_ov[0], 1'b1);
            chk($sformatf("rel_d%0d", j), {w_co[0], w_s[0]}, exp_v[j]);
            @(posedge clk); #2;
            if (j == 0) in_valid = 1'b0;
        end
        chk("rel_empty", w_ov[0], 1'b0);

        // Reset with beats in flight and a result held at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 32'h0000_0011 * (i + 1); b = 32'h8000_0003; ci = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", w_ov[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", w_ov[0], 1'b0);
        chk("mid_rst_s",     w_s[0],  32'd0);
        chk("mid_rst_co",    w_co[0], 1'b0);
        chk("mid_rst_flags", {w_ovf[0], w_zero[0], w_neg[0]}, 3'b000);
        chk("mid_rst_ready", w_ir[0], 1'b1);
        @(posedge clk); #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        n_stray = 0;
        for (int i = 0; i < 12; i++) begin
            if (w_ov != '0) n_stray++;
            @(posedge clk); #2;
        end
        chk("post_rst_stray", n_stray, 0);

        // Random sweep across all instances with random flow control.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       a = 32'h7FFF_FFFF;
                1:       a = 32'h8000_0000;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b   = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : $urandom;
            ci  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("drain%0d", d), q_exp[d].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
